// File: rtl/deserializer_rx.sv
// UART receiver: 2-flop synced line, 3-sample majority per bit, optional parity, registered result flags.
// Flags pulse PAR_MID+1 clk after the synced stop bit starts; no backpressure, every data_valid must be consumed.
module deserializer_rx #(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] EDGE_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] EDGE_S0   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] EDGE_S1   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] PAR_MID   = CW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  typedef struct packed {
    logic par_en;
    logic par_typ;
  } cfg_t;

  state_t                  state;
  state_t                  state_nxt;
  cfg_t                    cfg;
  logic                    rx_meta;
  logic                    rx_s;
  logic [CW-1:0]           edge_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shadow;
  logic                    smp_a;
  logic                    smp_b;
  logic                    bit_val;
  logic                    armed;
  logic                    par_bad;

  logic                    smp_tick;
  logic                    bit_end;
  logic                    maj_now;
  logic                    cur_bit;
  logic                    start_det;
  logic                    shift_en;
  logic                    par_chk;
  logic                    resolve;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  assign smp_tick = (edge_cnt == PAR_MID);
  assign bit_end  = (edge_cnt == EDGE_LAST);
  assign maj_now  = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  // The third vote is still on the line at PAR_MID; later in the bit it is held in bit_val.
  assign cur_bit  = smp_tick ? maj_now : bit_val;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = cur_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = cfg.par_en ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Resolving mid-bit leaves half a bit of idle line to catch a back-to-back start edge.
        if (smp_tick) begin
          resolve   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      shadow      <= '0;
      smp_a       <= 1'b0;
      smp_b       <= 1'b0;
      bit_val     <= 1'b0;
      armed       <= 1'b0;
      cfg.par_en  <= 1'b0;
      cfg.par_typ <= 1'b0;
      par_bad     <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      // The start-detect cycle itself is edge 0 of the start bit.
      if (state == IDLE) begin
        edge_cnt <= start_det ? CW'(1) : '0;
      end else if (resolve || bit_end) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + CW'(1);
      end

      if (edge_cnt == EDGE_S0) smp_a <= rx_s;
      if (edge_cnt == EDGE_S1) smp_b <= rx_s;
      if (smp_tick) bit_val <= maj_now;

      if (start_det) begin
        cfg.par_en  <= PAR_EN;
        cfg.par_typ <= PAR_TYP;
        bit_cnt     <= '0;
        par_bad     <= 1'b0;
        armed       <= 1'b0;
      end else if (state == IDLE && rx_s) begin
        armed <= 1'b1;
      end

      if (shift_en) begin
        shadow  <= {shadow[DATA_WIDTH-2:0], cur_bit};
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (par_chk) begin
        par_bad <= (cur_bit != ((^shadow) ^ cfg.par_typ));
      end

      // A low stop bit leaves the receiver disarmed so a held break cannot retrigger.
      if (resolve) begin
        armed <= cur_bit;
        if (!cur_bit) begin
          stp_err <= 1'b1;
        end else if (par_bad) begin
          par_err <= 1'b1;
        end else begin
          data_valid <= 1'b1;
          P_DATA     <= shadow;
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer_rx.sv
// Bench for deserializer_rx: frames are driven bit by bit, expected results are queued at send time
// and matched against pulses recorded by a monitor on the falling clock edge.
module tb_deserializer_rx;

  localparam int PRESCALE = 8;
  localparam int DW       = 8;

  localparam logic [1:0] K_VLD = 2'd0;
  localparam logic [1:0] K_PAR = 2'd1;
  localparam logic [1:0] K_STP = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX_IN = 1'b1;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [9:0]    exp_q[$];
  logic [9:0]    obs_q[$];
  logic [DW-1:0] model_pdata = '0;

  always #5 clk = ~clk;

  deserializer_rx #(
    .PRESCALE  (PRESCALE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) obs_q.push_back({K_VLD, P_DATA});
      if (par_err)    obs_q.push_back({K_PAR, P_DATA});
      if (stp_err)    obs_q.push_back({K_STP, P_DATA});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    RX_IN = b;
    repeat (PRESCALE) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic with_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = DW - 1; i >= 0; i--) drive_bit(d[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (P_DATA !== 8'h00) begin
      errors++;
      $display("FAIL reset_p_data got %h want 00", P_DATA);
    end
    checks++;
    if ({data_valid, par_err, stp_err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {data_valid, par_err, stp_err, busy});
    end
    rst = 1'b0;
    model_pdata = '0;
    idle(4);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_idle got %b want 0", busy);
    end
  endtask

  task automatic test_no_parity;
    logic [9:0] e, o;
    PAR_EN = 1'b0;
    exp_q.push_back({K_VLD, 8'hA5});
    model_pdata = 8'hA5;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    checks++;
    if (data_valid !== 1'b1) begin
      errors++;
      $display("FAIL nopar_latency data_valid got %b want 1", data_valid);
    end
    idle(3 * PRESCALE);
    checks++;
    if (busy !== 1'b0 || P_DATA !== 8'hA5) begin
      errors++;
      $display("FAIL nopar_final busy/P_DATA got %b/%h want 0/a5", busy, P_DATA);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL nopar_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL nopar_event got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_parity;
    logic [9:0] e, o;
    logic       good;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    good = (^8'h3C) ^ PAR_TYP;
    exp_q.push_back({K_VLD, 8'h3C});
    model_pdata = 8'h3C;
    send_frame(8'h3C, 1'b1, good, 1'b1);
    idle(2 * PRESCALE);
    exp_q.push_back({K_PAR, model_pdata});
    send_frame(8'h3C, 1'b1, ~good, 1'b1);
    idle(2 * PRESCALE);
    PAR_TYP = 1'b1;
    good = (^8'h07) ^ PAR_TYP;
    exp_q.push_back({K_VLD, 8'h07});
    model_pdata = 8'h07;
    send_frame(8'h07, 1'b1, good, 1'b1);
    idle(2 * PRESCALE);
    good = (^8'hE1) ^ PAR_TYP;
    exp_q.push_back({K_PAR, model_pdata});
    send_frame(8'hE1, 1'b1, ~good, 1'b1);
    idle(3 * PRESCALE);
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    checks++;
    if (P_DATA !== model_pdata) begin
      errors++;
      $display("FAIL parity_hold P_DATA got %h want %h", P_DATA, model_pdata);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL parity_event got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stop_err;
    logic [9:0] e, o;
    PAR_EN = 1'b0;
    exp_q.push_back({K_STP, model_pdata});
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    RX_IN = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL break_busy got %b want 0", busy);
    end
    idle(2 * PRESCALE);
    exp_q.push_back({K_VLD, 8'h5A});
    model_pdata = 8'h5A;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    idle(3 * PRESCALE);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stop_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_event got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_glitch;
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_detect busy got %b want 1", busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_abort busy got %b want 0", busy);
    end
    checks++;
    if (obs_q.size() != 0 || P_DATA !== model_pdata) begin
      errors++;
      $display("FAIL glitch_quiet pulses/P_DATA got %0d/%h want 0/%h", obs_q.size(), P_DATA, model_pdata);
    end
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [9:0] e, o;
    exp_q.push_back({K_VLD, 8'h01});
    exp_q.push_back({K_VLD, 8'hFE});
    model_pdata = 8'hFE;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1);
    idle(3 * PRESCALE);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_event got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0]    e, o;
    logic [DW-1:0] d;
    d = 8'hC3;
    drive_bit(1'b0);
    for (int i = DW - 1; i >= DW - 4; i--) drive_bit(d[i]);
    RX_IN = d[DW-5];
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy_before got %b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (P_DATA !== 8'h00 || {data_valid, par_err, stp_err, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_clear P_DATA/flags got %h/%b want 00/0000", P_DATA,
               {data_valid, par_err, stp_err, busy});
    end
    model_pdata = '0;
    RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(PRESCALE);
    exp_q.push_back({K_VLD, 8'h81});
    model_pdata = 8'h81;
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle(3 * PRESCALE);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midrst_event got %h want %h", o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
